// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC owner: one imem request at a time, output slot one edge after ack, one-entry skid under stall.
// Redirects take effect at once, or are held pending until an outstanding fetch acks (its data is then dropped).
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic [31:0] if_instr
);

  typedef enum logic [1:0] {START, FETCH, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_pc4_q, if_pc4_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        imem_req_q, imem_req_d;

  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        slot_free;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_d        = pend_q;
    pend_target_d = pend_target_q;
    skid_pc_d     = skid_pc_q;
    skid_instr_d  = skid_instr_q;
    if_valid_d    = if_valid_q;
    if_pc_d       = if_pc_q;
    if_pc4_d      = if_pc4_q;
    if_instr_d    = if_instr_q;

    target    = {redirect_target[31:2], 2'b00};
    pc_plus4  = pc_q + 32'd4;
    slot_free = !if_valid_q || !stall;

    if (if_valid_q && !stall) begin
      if_valid_d = 1'b0;
    end

    if (redirect_valid) begin
      if_valid_d   = 1'b0;
      skid_pc_d    = 32'd0;
      skid_instr_d = 32'd0;
      // The address must stay stable until the outstanding fetch acks.
      if (state_q == FETCH && !imem_ack) begin
        pend_d        = 1'b1;
        pend_target_d = target;
      end else begin
        pc_d    = target;
        pend_d  = 1'b0;
        state_d = FETCH;
      end
    end else begin
      case (state_q)
        START: state_d = FETCH;
        FETCH: begin
          if (imem_ack) begin
            if (pend_q) begin
              pc_d   = pend_target_q;
              pend_d = 1'b0;
            end else begin
              pc_d = pc_plus4;
              if (slot_free) begin
                if_valid_d = 1'b1;
                if_pc_d    = pc_q;
                if_pc4_d   = pc_plus4;
                if_instr_d = imem_rdata;
              end else begin
                skid_pc_d    = pc_q;
                skid_instr_d = imem_rdata;
                state_d      = HOLD;
              end
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            if_valid_d = 1'b1;
            if_pc_d    = skid_pc_q;
            if_pc4_d   = skid_pc_q + 32'd4;
            if_instr_d = skid_instr_q;
            state_d    = FETCH;
          end
        end
        default: state_d = START;
      endcase
    end

    imem_req_d = (state_d == FETCH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= START;
      pc_q          <= RESET_PC;
      pend_q        <= 1'b0;
      pend_target_q <= 32'd0;
      skid_pc_q     <= 32'd0;
      skid_instr_q  <= 32'd0;
      if_valid_q    <= 1'b0;
      if_pc_q       <= 32'd0;
      if_pc4_q      <= 32'd0;
      if_instr_q    <= 32'd0;
      imem_req_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_q        <= pend_d;
      pend_target_q <= pend_target_d;
      skid_pc_q     <= skid_pc_d;
      skid_instr_q  <= skid_instr_d;
      if_valid_q    <= if_valid_d;
      if_pc_q       <= if_pc_d;
      if_pc4_q      <= if_pc4_d;
      if_instr_q    <= if_instr_d;
      imem_req_q    <= imem_req_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_pc4    = if_pc4_q;
  assign if_instr  = if_instr_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed vector table, hand sequences for redirect/wrap/reset, random traffic vs a queue model.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall, redirect_valid, imem_ack;
  logic [31:0] redirect_target, imem_rdata;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_pc, if_pc4, if_instr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_pc4(if_pc4), .if_instr(if_instr)
  );

  // Reference model: PC, pending redirect, presented slot, and a skid queue of at most one word.
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        skid_m[$];
  bit          m_started;
  logic [31:0] m_pc, m_ptgt, m_spc, m_spc4, m_sinstr;
  bit          m_pend, m_valid;

  function automatic bit m_req();
    return m_started && (skid_m.size() == 0);
  endfunction

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return 32'hA500_0000 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic model_edge(input logic r, input logic s, input logic rv,
                            input logic [31:0] t, input logic a, input logic [31:0] d);
    bit   req_now, acked, old_valid;
    ent_t e;
    if (r) begin
      m_started = 0; m_pc = RST_PC; m_pend = 0; m_ptgt = 0;
      m_valid = 0; m_spc = 0; m_spc4 = 0; m_sinstr = 0;
      skid_m.delete();
      return;
    end
    req_now   = m_req();
    acked     = req_now && a;
    old_valid = m_valid;
    if (m_valid && !s) m_valid = 0;
    if (rv) begin
      m_valid = 0;
      skid_m.delete();
      if (req_now && !a) begin
        m_pend = 1; m_ptgt = t & ~32'd3;
      end else begin
        m_pc = t & ~32'd3; m_pend = 0;
      end
      m_started = 1;
    end else if (!m_started) begin
      m_started = 1;
    end else if (skid_m.size() > 0) begin
      if (!s) begin
        e = skid_m.pop_front();
        m_valid = 1; m_spc = e.pc; m_spc4 = e.pc + 32'd4; m_sinstr = e.instr;
      end
    end else if (acked) begin
      if (m_pend) begin
        m_pc = m_ptgt; m_pend = 0;
      end else if (!old_valid || !s) begin
        m_valid = 1; m_spc = m_pc; m_spc4 = m_pc + 32'd4; m_sinstr = d;
        m_pc = m_pc + 32'd4;
      end else begin
        e.pc = m_pc; e.instr = d;
        skid_m.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic rv,
                      input logic [31:0] t, input logic a, input logic [31:0] d);
    rst = r; stall = s; redirect_valid = rv; redirect_target = t;
    imem_ack = a; imem_rdata = d;
    @(posedge clk);
    model_edge(r, s, rv, t, a, d);
    #1;
    chk("model_req",   {31'd0, imem_req}, {31'd0, m_req()});
    chk("model_addr",  imem_addr, m_pc);
    chk("model_valid", {31'd0, if_valid}, {31'd0, m_valid});
    if (m_valid) begin
      chk("model_pc",    if_pc, m_spc);
      chk("model_pc4",   if_pc4, m_spc4);
      chk("model_instr", if_instr, m_sinstr);
    end
  endtask

  task automatic expect_out(input string tag, input logic req, input logic [31:0] addr,
                            input logic v, input logic [31:0] pc, input logic [31:0] instr);
    chk({tag, "_req"},   {31'd0, imem_req}, {31'd0, req});
    chk({tag, "_addr"},  imem_addr, addr);
    chk({tag, "_valid"}, {31'd0, if_valid}, {31'd0, v});
    if (v) begin
      chk({tag, "_pc"},    if_pc, pc);
      chk({tag, "_pc4"},   if_pc4, pc + 32'd4);
      chk({tag, "_instr"}, if_instr, instr);
    end
  endtask

  typedef struct {
    logic r, s, rv; logic [31:0] t; logic a; logic [31:0] d;
    logic e_req; logic [31:0] e_addr; logic e_valid;
    logic [31:0] e_pc, e_pc4, e_instr; logic full;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic s, input logic rv, input logic [31:0] t,
                              input logic a, input logic [31:0] d, input logic e_req,
                              input logic [31:0] e_addr, input logic e_valid, input logic [31:0] e_pc,
                              input logic [31:0] e_pc4, input logic [31:0] e_instr, input logic full);
    vec_t v;
    v.r = r; v.s = s; v.rv = rv; v.t = t; v.a = a; v.d = d;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_pc = e_pc; v.e_pc4 = e_pc4; v.e_instr = e_instr; v.full = full;
    return v;
  endfunction

  vec_t tbl[14];

  initial begin
    logic r, s, rv, a;
    // Reset, streaming, stall with skid, redirect on an ack.
    tbl[0]  = mk(1,0,0,0,     0,0,                    0,32'h0,  0,32'h0,  32'h0,  32'h0,              1);
    tbl[1]  = mk(0,0,0,0,     0,0,                    1,32'h0,  0,32'h0,  32'h0,  32'h0,              0);
    tbl[2]  = mk(0,0,0,0,     1,instr_of(32'h0),      1,32'h4,  1,32'h0,  32'h4,  instr_of(32'h0),    1);
    tbl[3]  = mk(0,0,0,0,     1,instr_of(32'h4),      1,32'h8,  1,32'h4,  32'h8,  instr_of(32'h4),    1);
    tbl[4]  = mk(0,0,0,0,     1,instr_of(32'h8),      1,32'hC,  1,32'h8,  32'hC,  instr_of(32'h8),    1);
    tbl[5]  = mk(0,1,0,0,     1,instr_of(32'hC),      0,32'h10, 1,32'h8,  32'hC,  instr_of(32'h8),    1);
    tbl[6]  = mk(0,1,0,0,     0,0,                    0,32'h10, 1,32'h8,  32'hC,  instr_of(32'h8),    1);
    tbl[7]  = mk(0,0,0,0,     0,0,                    1,32'h10, 1,32'hC,  32'h10, instr_of(32'hC),    1);
    tbl[8]  = mk(0,0,0,0,     1,instr_of(32'h10),     1,32'h14, 1,32'h10, 32'h14, instr_of(32'h10),   1);
    tbl[9]  = mk(0,0,0,0,     1,instr_of(32'h14),     1,32'h18, 1,32'h14, 32'h18, instr_of(32'h14),   1);
    tbl[10] = mk(0,0,0,0,     1,instr_of(32'h18),     1,32'h1C, 1,32'h18, 32'h1C, instr_of(32'h18),   1);
    tbl[11] = mk(0,0,0,0,     1,instr_of(32'h1C),     1,32'h20, 1,32'h1C, 32'h20, instr_of(32'h1C),   1);
    tbl[12] = mk(0,0,1,32'h100,1,instr_of(32'h20),    1,32'h100,0,32'h0,  32'h0,  32'h0,              0);
    tbl[13] = mk(0,0,0,0,     1,instr_of(32'h100),    1,32'h104,1,32'h100,32'h104,instr_of(32'h100),  1);

    rst = 1; stall = 0; redirect_valid = 0; redirect_target = 0; imem_ack = 0; imem_rdata = 0;
    #1;

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].r, tbl[i].s, tbl[i].rv, tbl[i].t, tbl[i].a, tbl[i].d);
      chk($sformatf("vec%0d_req", i),   {31'd0, imem_req}, {31'd0, tbl[i].e_req});
      chk($sformatf("vec%0d_addr", i),  imem_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d_valid", i), {31'd0, if_valid}, {31'd0, tbl[i].e_valid});
      if (tbl[i].full) begin
        chk($sformatf("vec%0d_pc", i),    if_pc, tbl[i].e_pc);
        chk($sformatf("vec%0d_pc4", i),   if_pc4, tbl[i].e_pc4);
        chk($sformatf("vec%0d_instr", i), if_instr, tbl[i].e_instr);
      end
    end

    // Redirects during a 3-cycle wait: latest target wins, waited data is dropped.
    step(1,0,0,0,0,0);
    step(0,0,1,32'h40,0,0);                   expect_out("rw_start", 1, 32'h40, 0, 0, 0);
    step(0,0,1,32'h200,0,0);                  expect_out("rw_w1", 1, 32'h40, 0, 0, 0);
    step(0,0,1,32'h300,0,0);                  expect_out("rw_w2", 1, 32'h40, 0, 0, 0);
    step(0,0,0,0,0,0);                        expect_out("rw_w3", 1, 32'h40, 0, 0, 0);
    step(0,0,0,0,1,32'hDEAD_BEEF);            expect_out("rw_ack", 1, 32'h300, 0, 0, 0);
    step(0,0,0,0,1,instr_of(32'h300));        expect_out("rw_next", 1, 32'h304, 1, 32'h300, instr_of(32'h300));

    // Misaligned target is forced to a word, and PC+4 wraps to zero.
    step(0,0,1,32'hFFFF_FFFE,1,32'h1234_5678); expect_out("wrap_redir", 1, 32'hFFFF_FFFC, 0, 0, 0);
    step(0,0,0,0,1,instr_of(32'hFFFF_FFFC));   expect_out("wrap_ack", 1, 32'h0, 1, 32'hFFFF_FFFC, instr_of(32'hFFFF_FFFC));

    // Reset while a fetch is outstanding.
    step(0,0,0,0,0,0);
    step(1,0,0,0,0,0);                        expect_out("rmid_rst", 0, RST_PC, 0, 0, 0);
    step(0,0,0,0,0,0);                        expect_out("rmid_start", 1, RST_PC, 0, 0, 0);
    step(0,0,0,0,1,instr_of(RST_PC));         expect_out("rmid_first", 1, RST_PC + 32'd4, 1, RST_PC, instr_of(RST_PC));

    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      s  = ($urandom_range(0, 99) < 30);
      rv = ($urandom_range(0, 99) < 8);
      a  = m_req() && ($urandom_range(0, 99) < 60);
      step(r, s, rv, $urandom(), a, $urandom());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
